// File: rtl/alu1_result_stage_pkg.sv
// Shared Alu1 constants: command codes, condition-flag layout and the flag
// derivation used by the result stage.
package alu1_result_stage_pkg;

  localparam int ALU1_WIDTH     = 64;
  localparam int ALU1_CMD_WIDTH = 4;

  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_PASS       = 4'd0;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_INC        = 4'd1;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_ADD        = 4'd2;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_ADD_PLUS1  = 4'd3;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_SUB_MINUS1 = 4'd4;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_SUB        = 4'd5;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_DEC        = 4'd6;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_AND        = 4'd7;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_OR         = 4'd8;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_XOR        = 4'd9;
  localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_CMD_NOT        = 4'd10;

  localparam int ALU1_FLAGS_WIDTH = 4;
  localparam int ALU1_FLAG_Z      = 3;
  localparam int ALU1_FLAG_N      = 2;
  localparam int ALU1_FLAG_C      = 1;
  localparam int ALU1_FLAG_V      = 0;

  // Overflow is judged from operand sign bits as applied to the ALU, so
  // subtraction compares a against the un-inverted b.
  function automatic logic [ALU1_FLAGS_WIDTH-1:0] alu1_flags(
    input logic [ALU1_CMD_WIDTH-1:0] cmd,
    input logic [ALU1_WIDTH-1:0]     result,
    input logic                      co,
    input logic                      a_msb,
    input logic                      b_msb
  );
    logic [ALU1_FLAGS_WIDTH-1:0] flags;
    logic                        rm;
    rm                 = result[ALU1_WIDTH-1];
    flags              = '0;
    flags[ALU1_FLAG_Z] = (result == '0);
    flags[ALU1_FLAG_N] = rm;
    case (cmd)
      ALU1_CMD_ADD, ALU1_CMD_ADD_PLUS1: begin
        flags[ALU1_FLAG_C] = co;
        flags[ALU1_FLAG_V] = (a_msb == b_msb) && (rm != a_msb);
      end
      ALU1_CMD_SUB, ALU1_CMD_SUB_MINUS1: begin
        flags[ALU1_FLAG_C] = co;
        flags[ALU1_FLAG_V] = (a_msb != b_msb) && (rm != a_msb);
      end
      ALU1_CMD_INC: begin
        flags[ALU1_FLAG_C] = co;
        flags[ALU1_FLAG_V] = !a_msb && rm;
      end
      ALU1_CMD_DEC: begin
        flags[ALU1_FLAG_C] = co;
        flags[ALU1_FLAG_V] = a_msb && !rm;
      end
      default: ;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/alu1_result_fifo.sv
// In-order FIFO with a registered head entry; DEPTH must be a power of two
// so the pointers wrap by natural overflow.
module alu1_result_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [DATA_WIDTH-1:0]         push_data,
  output logic                          pop_valid,
  input  logic                          pop_ready,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
  logic [CNT_W-1:0]      count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  push, pop;

  assign push_ready = (count != CNT_W'(DEPTH));
  assign pop_valid  = (count != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = head_q;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_d = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_d  = count;
    if (push && !pop) count_d = count + CNT_W'(1);
    if (pop && !push) count_d = count - CNT_W'(1);
    // The next head comes straight from push_data when it lands in the slot
    // that is about to become the head (empty, or single entry being popped).
    head_d = head_q;
    if (count_d != '0) begin
      if (push && (wr_ptr == rd_ptr_d)) head_d = push_data;
      else                              head_d = mem[rd_ptr_d];
    end
  end

  // NOTE: the storage array has no reset; count and the reset head register
  // decide what is visible, so stale contents can never reach the output.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      rd_ptr <= rd_ptr_d;
      wr_ptr <= wr_ptr_d;
      count  <= count_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/alu1_result_stage.sv
// Registered Alu1 writeback stage: derives Z/N/C/V at push time, buffers
// results in order, and tracks a sticky overflow bit and an op counter.
module alu1_result_stage
  import alu1_result_stage_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CMD_WIDTH = ALU1_CMD_WIDTH,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CMD_WIDTH-1:0]        in_cmd,
  input  logic [WIDTH-1:0]            in_result,
  input  logic                        in_co,
  input  logic                        in_a_msb,
  input  logic                        in_b_msb,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_result,
  output logic [ALU1_FLAGS_WIDTH-1:0] out_flags,
  output logic [CMD_WIDTH-1:0]        out_cmd,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        sticky_v,
  input  logic                        sticky_clr,
  output logic [15:0]                 op_count
);

  localparam int PAYLOAD_W = CMD_WIDTH + TAG_WIDTH + ALU1_FLAGS_WIDTH + WIDTH;

  logic [ALU1_FLAGS_WIDTH-1:0] in_flags;
  logic [PAYLOAD_W-1:0]        push_data, pop_data;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic                        push;

  // WIDTH equals the Alu1 width, so the result feeds the shared helper as is.
  assign in_flags  = alu1_flags(in_cmd, in_result, in_co, in_a_msb, in_b_msb);
  assign push_data = {in_cmd, in_tag, in_flags, in_result};
  assign push      = in_valid && in_ready;

  alu1_result_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data),
    .count      (count)
  );

  assign {out_cmd, out_tag, out_flags, out_result} = pop_data;

  // A new overflow outranks a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
      op_count <= '0;
    end else begin
      if (push && in_flags[ALU1_FLAG_V]) sticky_v <= 1'b1;
      else if (sticky_clr)               sticky_v <= 1'b0;
      if (push) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu1_result_stage.sv
// Directed and randomised bench for alu1_result_stage with a queue scoreboard.
module tb_alu1_result_stage;
  import alu1_result_stage_pkg::*;

  localparam int W  = 64;
  localparam int CW = ALU1_CMD_WIDTH;
  localparam int TW = 4;
  localparam int D  = 2;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_co, in_a_msb, in_b_msb;
  logic [CW-1:0] in_cmd, out_cmd;
  logic [W-1:0]  in_result, out_result;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready, sticky_v, sticky_clr;
  logic [3:0]    out_flags;
  logic [15:0]   op_count;

  typedef struct packed {
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic [CW-1:0] cmd;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count;
  logic        exp_sticky;

  alu1_result_stage #(.WIDTH(W), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_result(in_result), .in_co(in_co), .in_a_msb(in_a_msb),
    .in_b_msb(in_b_msb), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_cmd(out_cmd), .out_tag(out_tag),
    .sticky_v(sticky_v), .sticky_clr(sticky_clr), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference flags {Z,N,C,V}, written from the behavioural description.
  function automatic logic [3:0] ref_flags(input logic [CW-1:0] cmd, input logic [W-1:0] r,
                                           input logic co, input logic a, input logic b);
    logic z, n, c, v;
    z = (r == 64'd0);
    n = r[W-1];
    c = 1'b0;
    v = 1'b0;
    if (cmd == ALU1_CMD_INC || cmd == ALU1_CMD_ADD || cmd == ALU1_CMD_ADD_PLUS1 ||
        cmd == ALU1_CMD_SUB_MINUS1 || cmd == ALU1_CMD_SUB || cmd == ALU1_CMD_DEC) c = co;
    if (cmd == ALU1_CMD_ADD || cmd == ALU1_CMD_ADD_PLUS1) v = (a == b) && (n != a);
    if (cmd == ALU1_CMD_SUB || cmd == ALU1_CMD_SUB_MINUS1) v = (a != b) && (n != a);
    if (cmd == ALU1_CMD_INC) v = !a && n;
    if (cmd == ALU1_CMD_DEC) v = a && !n;
    return {z, n, c, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [CW-1:0] cmd, input logic [W-1:0] r, input logic co,
                       input logic a, input logic b, input logic [TW-1:0] tag);
    in_valid  = 1'b1;
    in_cmd    = cmd;
    in_result = r;
    in_co     = co;
    in_a_msb  = a;
    in_b_msb  = b;
    in_tag    = tag;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_cmd    = 'x;
    in_result = 'x;
    in_co     = 1'bx;
    in_a_msb  = 1'bx;
    in_b_msb  = 1'bx;
    in_tag    = 'x;
  endtask

  // Called at a falling edge with inputs settled: compare head, update model, clock once.
  task automatic tick();
    bit   do_push, do_pop;
    exp_t e;
    check("in_ready", 64'(in_ready), 64'(sb.size() != D));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_result", out_result, sb[0].result);
      check("out_flags", 64'(out_flags), 64'(sb[0].flags));
      check("out_cmd", 64'(out_cmd), 64'(sb[0].cmd));
      check("out_tag", 64'(out_tag), 64'(sb[0].tag));
    end
    do_push = in_valid && (sb.size() < D);
    do_pop  = out_ready && (sb.size() > 0);
    if (do_pop) void'(sb.pop_front());
    if (do_push) begin
      e.result = in_result;
      e.flags  = ref_flags(in_cmd, in_result, in_co, in_a_msb, in_b_msb);
      e.cmd    = in_cmd;
      e.tag    = in_tag;
      sb.push_back(e);
      exp_count++;
    end
    if (do_push && e.flags[0]) exp_sticky = 1'b1;
    else if (sticky_clr)       exp_sticky = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("op_count", 64'(op_count), 64'(exp_count));
    check("sticky_v", 64'(sticky_v), 64'(exp_sticky));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_sticky", 64'(sticky_v), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    exp_count  = '0;
    exp_sticky = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    sticky_clr = 1'b0;
    exp_count  = '0;
    exp_sticky = 1'b0;
    idle();
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_cmd", 64'(out_cmd), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_sticky", 64'(sticky_v), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow on ADD: 0x7FFF..F + 1
    drive(ALU1_CMD_ADD, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd1);
    tick();
    idle();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_flags", 64'(out_flags), 64'b0101);
    check("add_sticky", 64'(sticky_v), 64'd1);
    check("add_count", 64'(op_count), 64'd1);
    tick();

    drive(ALU1_CMD_SUB, 64'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    idle();
    check("sub_flags", 64'(out_flags), 64'b1010);
    tick();

    drive(ALU1_CMD_AND, 64'd0, 1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    idle();
    check("and_flags", 64'(out_flags), 64'b1000);
    tick();

    // Set beats clear, then clear with a non-overflowing op
    sticky_clr = 1'b1;
    drive(ALU1_CMD_ADD, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd4);
    tick();
    check("sticky_set_wins", 64'(sticky_v), 64'd1);
    drive(ALU1_CMD_OR, 64'd5, 1'b0, 1'b0, 1'b0, 4'd5);
    tick();
    check("sticky_cleared", 64'(sticky_v), 64'd0);
    sticky_clr = 1'b0;
    idle();
    tick();
    tick();

    // Backpressure: fill, stall, then drain in order
    do_reset();
    out_ready = 1'b0;
    drive(ALU1_CMD_XOR, 64'h11, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(ALU1_CMD_INC, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd1);
    tick();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    drive(ALU1_CMD_DEC, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd2);
    tick();
    tick();
    check("bp_held_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    idle();
    check("bp_tag2", 64'(out_tag), 64'd2);
    check("bp_tag2_flags", 64'(out_flags), 64'b0011);
    tick();
    check("bp_count", 64'(op_count), 64'd3);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Random traffic: wrap, simultaneous push/pop, unknown cmd codes
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] r;
      r = {32'($urandom), 32'($urandom)};
      if ($urandom_range(3) == 0) r = '0;
      drive(CW'($urandom_range(12)), r, 1'($urandom), 1'($urandom), 1'($urandom),
            TW'($urandom));
      in_valid   = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(2) != 0);
      sticky_clr = ($urandom_range(4) == 0);
      tick();
    end
    idle();
    sticky_clr = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reset with two entries buffered discards them
    out_ready = 1'b0;
    drive(ALU1_CMD_ADD, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'd6);
    tick();
    drive(ALU1_CMD_OR, 64'h3, 1'b0, 1'b0, 1'b0, 4'd7);
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    do_reset();
    out_ready = 1'b1;
    tick();
    drive(ALU1_CMD_PASS, 64'h1234, 1'b0, 1'b0, 1'b0, 4'hA);
    tick();
    idle();
    check("post_rst_tag", 64'(out_tag), 64'hA);
    tick();
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
